// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one asynchronous SRAM-style bus between port A (video fetch) and
//   port B (CPU). A granted access runs IDLE -> ACCESS (WAIT_STATES+1 cycles)
//   -> DONE. Every bus output is registered. mem_dir drives the data-pin
//   bidir select directly: 1 releases the pins, 0 drives mem_dout.
//
//   Ports:
//     clk, reset              rising-edge clock, synchronous active-high reset
//     a_req/a_wr/a_addr/a_wdata  port A request (held until a_ack)
//     a_ack, a_rdata          one-cycle completion pulse, last read data
//     b_*                     same set for port B
//     mem_addr, mem_dout      registered bus address / write data
//     mem_din                 read data from the pins
//     mem_dir, mem_rd, mem_wr pin direction, read strobe, write strobe
//
//   Build option:
//     MEM_ARB_FIXED_PRIORITY_EN  port A wins simultaneous requests; when
//                                undefined, simultaneous requests alternate.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dout,
  input  logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_dir,
  output logic                  mem_rd,
  output logic                  mem_wr
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t     state, state_nxt;
  logic       last_grant;   // 0 = A, 1 = B
  logic       gnt;          // owner of the access in flight
  logic [3:0] wait_cnt;
  logic       start;        // grant taken on this edge
  logic       grant_b;
  logic       acc_end;      // last ACCESS cycle
  req_t       req_a, req_b, req_sel;

  assign req_a = {a_wr, a_addr, a_wdata};
  assign req_b = {b_wr, b_addr, b_wdata};

  // Next state, grant decision and access-end detect.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    grant_b   = 1'b0;
    acc_end   = 1'b0;
    case (state)
      IDLE: begin
        start = a_req | b_req;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        grant_b = b_req & ~a_req;
`else
        // B wins when alone, or on a tie when A had the previous grant.
        grant_b = b_req & (~a_req | ~last_grant);
`endif
        if (start) state_nxt = ACCESS;
      end
      ACCESS: begin
        acc_end = (wait_cnt == 4'd0);
        if (acc_end) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    req_sel = grant_b ? req_b : req_a;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Arbitration history and current owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      gnt        <= 1'b0;
    end else if (start) begin
      last_grant <= grant_b;
      gnt        <= grant_b;
    end
  end

  // Wait-state counter: loaded on grant, counts down through ACCESS.
  always_ff @(posedge clk) begin
    if (reset)                        wait_cnt <= 4'd0;
    else if (start)                   wait_cnt <= WAIT_LOAD;
    else if (state == ACCESS && !acc_end) wait_cnt <= wait_cnt - 4'd1;
  end

  // Address and write data stay put after the access so the bus is quiet
  // and write data keeps its hold time through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr <= '0;
      mem_dout <= '0;
    end else if (start) begin
      mem_addr <= req_sel.addr;
      mem_dout <= req_sel.wdata;
    end
  end

  // Strobes and pin direction. The pins are released one cycle after the
  // write strobe falls, giving the SRAM data hold time.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      mem_dir <= 1'b1;
    end else if (start) begin
      mem_rd  <= ~req_sel.wr;
      mem_wr  <= req_sel.wr;
      mem_dir <= ~req_sel.wr;
    end else if (acc_end) begin
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
    end else if (state == DONE) begin
      mem_dir <= 1'b1;
    end
  end

  // Acks are single-cycle pulses covering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
    end else begin
      a_ack <= acc_end & ~gnt;
      b_ack <= acc_end & gnt;
    end
  end

  // Read data lands only in the owner's register; mem_rd is still high on
  // the capturing edge, which distinguishes reads from writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (acc_end && mem_rd) begin
      if (gnt) b_rdata <= mem_din;
      else     a_rdata <= mem_din;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Three arbiter instances (WAIT_STATES = 1, 0, 15) each driven by their own
//   requesters and checked every cycle against a transaction timeline model:
//   a grant at the end of cycle t0 implies ACCESS for t0+1..t0+WS+1, DONE at
//   t0+WS+2 and the next grant opportunity at the end of t0+WS+3.
//   Phases per instance: directed accesses (read, write, isolation, reset
//   during a write), continuous contention, then randomized traffic.
module tb_mem_bus_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int NI = 3;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_ws
    localparam int WS = (gi == 0) ? 1 : (gi == 1) ? 0 : 15;

    logic          reset, a_req, a_wr, a_ack, b_req, b_wr, b_ack;
    logic [AW-1:0] a_addr, b_addr, mem_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_dout, mem_din;
    logic          mem_dir, mem_rd, mem_wr;
    bit            fin;

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
      .mem_dir(mem_dir), .mem_rd(mem_rd), .mem_wr(mem_wr)
    );

    initial begin : run
      int cyc, t0, d, phase, step, issue_c, ack_c, rst_cnt, nack, ndone, p2_end;
      int rd_cnt, wr_cnt, dir_cnt, iso_cnt;
      bit busy, g, g_wr, last_g, in_acc, in_done, issued;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_dout, e_ra, e_rb, din_fix;
      string p;

      p = $sformatf("ws%0d_", WS);
      reset = 1'b1; a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0; mem_din = '0;
      cyc = 0; t0 = 0; d = 0; phase = 0; step = 0; issue_c = 0; ack_c = -1;
      rst_cnt = 2; nack = 0; ndone = 0; p2_end = 0;
      rd_cnt = 0; wr_cnt = 0; dir_cnt = 0; iso_cnt = 0;
      busy = 1'b0; g = 1'b0; g_wr = 1'b0; last_g = 1'b1; issued = 1'b0;
      in_acc = 1'b0; in_done = 1'b0;
      e_addr = '0; e_dout = '0; e_ra = '0; e_rb = '0; din_fix = '0;

      while (phase < 3 && cyc < 5000) begin
        // ---- model: advance one clock edge ----
        @(posedge clk);
        if (reset) begin
          busy = 1'b0; last_g = 1'b1;
          e_addr = '0; e_dout = '0; e_ra = '0; e_rb = '0;
        end else if (busy) begin
          if (cyc == t0 + WS + 1 && !g_wr) begin
            if (g) e_rb = mem_din;
            else   e_ra = mem_din;
          end
          if (cyc == t0 + WS + 2) busy = 1'b0;
        end else if (a_req || b_req) begin
          g      = (a_req && b_req) ? (FIXED ? 1'b0 : !last_g) : b_req;
          last_g = g;
          busy   = 1'b1;
          t0     = cyc;
          g_wr   = g ? b_wr : a_wr;
          e_addr = g ? b_addr : a_addr;
          e_dout = g ? b_wdata : a_wdata;
        end
        cyc++;

        // ---- compare outputs of the current cycle ----
        @(negedge clk);
        d       = cyc - t0;
        in_acc  = busy && d >= 1 && d <= WS + 1;
        in_done = busy && d == WS + 2;
        chk({p, "a_ack"},   32'(a_ack),    32'(in_done && !g));
        chk({p, "b_ack"},   32'(b_ack),    32'(in_done && g));
        chk({p, "mem_rd"},  32'(mem_rd),   32'(in_acc && !g_wr));
        chk({p, "mem_wr"},  32'(mem_wr),   32'(in_acc && g_wr));
        chk({p, "mem_dir"}, 32'(mem_dir),  32'(!((in_acc || in_done) && g_wr)));
        chk({p, "excl"},    32'(mem_rd & mem_wr), 32'(0));
        chk({p, "addr"},    32'(mem_addr), 32'(e_addr));
        chk({p, "dout"},    32'(mem_dout), 32'(e_dout));
        chk({p, "a_rdata"}, 32'(a_rdata),  32'(e_ra));
        chk({p, "b_rdata"}, 32'(b_rdata),  32'(e_rb));

        // ---- drive inputs for the next cycle ----
        if (rst_cnt > 0) begin
          rst_cnt--;
          if (rst_cnt == 0) begin
            reset = 1'b0;
            if (step == 4) begin
              // contention: both ports read continuously
              phase = 1; step = 0; issued = 1'b0;
              a_req = 1'b1; a_wr = 1'b0; a_addr = AW'($urandom);
              b_req = 1'b1; b_wr = 1'b0; b_addr = AW'($urandom);
            end
          end
        end else begin
          case (phase)
            0: begin
              if (!issued) begin
                if (!busy) begin
                  issued = 1'b1; issue_c = cyc; ack_c = -1;
                  rd_cnt = 0; wr_cnt = 0; dir_cnt = 0; iso_cnt = 0;
                  case (step)
                    0: begin a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h1234; din_fix = 8'hA5; end
                    1: begin b_req = 1'b1; b_wr = 1'b1; b_addr = 16'h0042; b_wdata = 8'h5A; end
                    2: begin a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h0011; din_fix = 8'h11; end
                    3: begin b_req = 1'b1; b_wr = 1'b0; b_addr = 16'h0022; din_fix = 8'h22; end
                    default: begin a_req = 1'b1; a_wr = 1'b1; a_addr = 16'h0077; a_wdata = 8'h3C; end
                  endcase
                end
              end else begin
                rd_cnt  += int'(mem_rd);
                wr_cnt  += int'(mem_wr);
                dir_cnt += int'(!mem_dir);
                iso_cnt += int'(a_ack);
                if (a_ack || b_ack) ack_c = cyc;
                if (step == 4 && in_acc) begin
                  // reset lands while the write strobe is active
                  reset = 1'b1; rst_cnt = 2; a_req = 1'b0;
                end else if (in_done) begin
                  chk({p, "latency"}, ack_c - issue_c, WS + 2);
                  case (step)
                    0: chk({p, "rd_len"}, rd_cnt, WS + 1);
                    1: begin
                      chk({p, "wr_len"},  wr_cnt,  WS + 1);
                      chk({p, "dir_len"}, dir_cnt, WS + 2);
                    end
                    3: begin
                      chk({p, "iso_ack"},   iso_cnt,      0);
                      chk({p, "iso_rdata"}, 32'(a_rdata), 32'h11);
                    end
                    default: ;
                  endcase
                  a_req = 1'b0; b_req = 1'b0; issued = 1'b0; step++;
                end
              end
              mem_din = din_fix;
            end
            1: begin
              mem_din = DW'($urandom);
              if (a_ack || b_ack) begin
                if (nack < 4) chk({p, "order"}, 32'(b_ack), FIXED ? 0 : nack % 2);
                nack++;
              end
              if (in_done) begin
                ndone++;
                if (g) b_addr = AW'($urandom);
                else   a_addr = AW'($urandom);
                if (ndone == 4) begin
                  chk({p, "order_n"}, nack, 4);
                  a_req = 1'b0; b_req = 1'b0;
                  phase = 2; p2_end = cyc + 40 * (WS + 3);
                end
              end
            end
            default: begin
              mem_din = DW'($urandom);
              // port A requester
              if (in_done && !g) begin
                a_req = 1'($urandom_range(0, 1)); a_wr = 1'($urandom_range(0, 1));
                a_addr = AW'($urandom); a_wdata = DW'($urandom);
              end else if (!a_req) begin
                if ($urandom_range(0, 2) == 0) begin
                  a_req = 1'b1; a_wr = 1'($urandom_range(0, 1));
                  a_addr = AW'($urandom); a_wdata = DW'($urandom);
                end
              end else if (!(busy && !g) && $urandom_range(0, 15) == 0) begin
                a_req = 1'b0;  // withdraw before grant
              end
              // port B requester
              if (in_done && g) begin
                b_req = 1'($urandom_range(0, 1)); b_wr = 1'($urandom_range(0, 1));
                b_addr = AW'($urandom); b_wdata = DW'($urandom);
              end else if (!b_req) begin
                if ($urandom_range(0, 2) == 0) begin
                  b_req = 1'b1; b_wr = 1'($urandom_range(0, 1));
                  b_addr = AW'($urandom); b_wdata = DW'($urandom);
                end
              end else if (!(busy && g) && $urandom_range(0, 15) == 0) begin
                b_req = 1'b0;
              end
              if (cyc >= p2_end) begin
                a_req = 1'b0; b_req = 1'b0; phase = 3;
              end
            end
          endcase
        end
      end
      chk({p, "phases"}, phase, 3);
      fin = 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk);
      if (g_ws[0].fin && g_ws[1].fin && g_ws[2].fin) break;
    end
    chk("all_done", {29'b0, g_ws[2].fin, g_ws[1].fin, g_ws[0].fin}, 32'h7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external asynchronous SRAM-style bus (address, bidirectional data, read/write strobes) between two requesters: port A (video fetch) and port B (CPU).
- Runs the bus access sequence and drives the direction select of the data-pin Bidir instance (mem_dir maps directly to its sel_in).
- Latches read data, returns a one-cycle ack to the winning requester, and arbitrates round-robin.

Parameters:
ADDR_WIDTH, 16, width of a_addr, b_addr and mem_addr
DATA_WIDTH, 8, width of all data ports
WAIT_STATES, 1, extra ACCESS cycles beyond the first (legal range 0..15)

Ports:
clk  input  1  system clock, all logic on its rising edge
reset  input  1  synchronous, active-high reset
a_req  input  1  port A request; held high until a_ack
a_wr  input  1  port A: 1 = write, 0 = read
a_addr  input  ADDR_WIDTH  port A address
a_wdata  input  DATA_WIDTH  port A write data
a_ack  output  1  one-cycle pulse: port A access complete
a_rdata  output  DATA_WIDTH  port A read data, valid while a_ack=1 and held until A's next read completes
b_req, b_wr, b_addr, b_wdata, b_ack, b_rdata  same as the A ports, for port B
mem_addr  output  ADDR_WIDTH  registered bus address
mem_dout  output  DATA_WIDTH  registered write data to the Bidir out
mem_din  input  DATA_WIDTH  read data from the Bidir in
mem_dir  output  1  1 = pins are input (released), 0 = drive mem_dout
mem_rd  output  1  read strobe, active high
mem_wr  output  1  write strobe, active high

Behaviour:
- Design rules:
  - One clock domain, one always block per register group.
  - Reset is synchronous, active-high, and takes effect on the next edge from any state.
- Reset values:
  - State = IDLE, last_grant = B.
  - a_ack = b_ack = 0; a_rdata = b_rdata = 0.
  - mem_addr = 0, mem_dout = 0, mem_dir = 1, mem_rd = mem_wr = 0.
- States: IDLE, ACCESS, DONE. Wait counter is 4 bits.
- IDLE:
  - Samples a_req and b_req.
  - If exactly one is high, that port is granted.
  - If both are high, the port != last_grant is granted.
  - On grant: register addr, wdata and direction into mem_*, set last_grant, load counter = WAIT_STATES, go to ACCESS.
  - In the same edge: mem_rd = ~wr, mem_wr = wr, mem_dir = ~wr.
- ACCESS:
  - Strobes and bus held stable.
  - Counter decrements each cycle; leave when counter = 0.
  - Total ACCESS length is WAIT_STATES+1 cycles.
  - On the leaving edge:
    - Read: mem_din is captured into the granted port's rdata.
    - Both mem_rd and mem_wr deassert.
    - The granted port's ack is set.
    - Go to DONE.
- DONE:
  - Ack high for exactly this cycle.
  - For a write, mem_dir stays 0 and mem_dout is held (hold time); for a read, mem_dir is already 1.
  - Next edge: ack = 0, mem_dir = 1, go to IDLE.
- Latency: with req high in IDLE cycle 0, ack appears in cycle WAIT_STATES+2. Access period is WAIT_STATES+3 cycles.
- Request rules:
  - The requester must keep addr, wdata and wr stable from req until ack.
  - req still high in the IDLE cycle after DONE counts as a new request.
  - A req dropped before grant is simply not serviced. Dropping req after grant does not abort the access.
- Bus protocol guarantees:
  - mem_rd and mem_wr are never both 1.
  - mem_dir = 0 only during write ACCESS and write DONE.
  - The non-granted port's ack and rdata never change.
- Reset mid-access: strobes and acks drop on that edge, mem_dir = 1. No partial rdata update occurs.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIORITY_EN.
- Defined: on simultaneous requests port A always wins; last_grant is ignored (still maintained).
- Undefined: round-robin as above. Port B then gets at least one access per two A accesses under contention.

Test Plan:
1. Reset: assert reset for 2 cycles mid write-ACCESS (WAIT_STATES=1) -> next cycle mem_wr=0, mem_dir=1, a_ack=b_ack=0, state IDLE.
2. Single read: A reads addr 0x1234 with mem_din=0xA5 -> mem_rd high cycles 1-2, a_ack in cycle 3 with a_rdata=0xA5, mem_dir=1 throughout.
3. Single write: B writes 0x5A to 0x0042 -> mem_wr high cycles 1-2, mem_dir=0 cycles 1-3, b_ack cycle 3, mem_dir=1 cycle 4.
4. Contention: a_req and b_req held high continuously after reset -> grants A,B,A,B (acks spaced 4 cycles apart). With MEM_ARB_FIXED_PRIORITY_EN -> A,A,A.
5. WAIT_STATES=0: read -> ack in cycle 2. WAIT_STATES=15: ack in cycle 17, mem_rd high exactly 16 cycles.
6. Isolation: interleaved A read of 0x11 then B read of 0x22 -> a_rdata stays 0x11 through B's access and a_ack never pulses during B's access.
